if_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of the decode stage.
- Owns the PC and drives a req/ack instruction-memory port.
- Delivers a registered {pc_o, inst_o, valid_o} to decode, honouring pipeline stall, branch redirect (with MIPS delay slot) and flush.
- Buffers one returned instruction while decode is stalled, and discards stale responses after a flush.

---
 rtl/if_fetch_pkg.sv | 17 +
 rtl/if_fetch_if.sv | 27 ++
 rtl/if_fetch.sv | 175 +++++++++++++++++
 tb/tb_if_fetch.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage.
// State encodings, reset level and bus widths.
package if_fetch_pkg;

    localparam logic RSTN_ENABLE = 1'b0;
    localparam int INST_ADDR_W = 32;
    localparam int INST_W = 32;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DROP  = 2'd3
    } if_state_t;

endpackage

// File: rtl/if_fetch_if.sv
// Instruction-memory req/ack port.
// Fetch is master; memory answers with ack and rdata.
interface if_fetch_if #(
    parameter int ADDR_W = if_fetch_pkg::INST_ADDR_W,
    parameter int DATA_W = if_fetch_pkg::INST_W
);

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output addr,
        input  ack,
        input  rdata
    );

    modport slave (
        input  req,
        input  addr,
        output ack,
        output rdata
    );

endinterface

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, drives imem,
// buffers one instruction under stall, drops stale data.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_W = INST_ADDR_W,
    parameter int DATA_W = INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    if_fetch_if.master        imem,
    output logic [ADDR_W-1:0] pc_o,
    output logic [DATA_W-1:0] inst_o,
    output logic              valid_o,
    output logic              stallreq_o
);

    if_state_t         state;
    if_state_t         state_nxt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redir_pend;
    logic [ADDR_W-1:0] hold_pc;
    logic [DATA_W-1:0] hold_inst;
    logic [ADDR_W-1:0] nxt;
    logic [ADDR_W-1:0] tgt_al;
    logic [ADDR_W-1:0] new_al;
    logic              req;
    logic              busy;

    assign tgt_al = {branch_target_i[ADDR_W-1:2], 2'b00};
    assign new_al = {new_pc_i[ADDR_W-1:2], 2'b00};
    assign busy   = req & ~imem.ack;

    // Address after the current instruction: branch, pending redirect, or +4.
    always_comb begin
        nxt = fetch_pc + ADDR_W'(4);
        if (branch_flag_i)
            nxt = tgt_al;
        else if (redir_pend)
            nxt = redir_tgt;
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic; flush wins over stall and branch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  state_nxt = S_FETCH;
            S_FETCH: begin
                if (flush_i)
                    state_nxt = imem.ack ? S_FETCH : S_DROP;
                else if (imem.ack && stall_i)
                    state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (flush_i || !stall_i)
                    state_nxt = S_FETCH;
            end
            S_DROP: begin
                if (imem.ack)
                    state_nxt = S_FETCH;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Bus outputs; address is always fetch_pc, which holds until ack.
    always_comb begin
        req = 1'b0;
        unique case (state)
            S_FETCH, S_DROP: req = 1'b1;
            default:         req = 1'b0;
        endcase
        imem.req   = req;
        imem.addr  = fetch_pc;
        stallreq_o = req & ~imem.ack;
    end

    // PC and redirect tracking; a flush mid-request parks its target.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            fetch_pc   <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= RESET_PC;
        end else if (flush_i) begin
            redir_pend <= 1'b0;
            if (busy)
                redir_tgt <= new_al;
            else
                fetch_pc <= new_al;
        end else begin
            unique case (state)
                S_FETCH: begin
                    if (imem.ack) begin
                        fetch_pc   <= nxt;
                        redir_pend <= 1'b0;
                    end else if (branch_flag_i) begin
                        redir_pend <= 1'b1;
                        redir_tgt  <= tgt_al;
                    end
                end
                S_HOLD: begin
                    if (branch_flag_i)
                        fetch_pc <= tgt_al;
                end
                S_DROP: begin
                    if (imem.ack)
                        fetch_pc <= redir_tgt;
                end
                default: ;
            endcase
        end
    end

    // Hold buffer captures a response that decode cannot take yet.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            hold_pc   <= '0;
            hold_inst <= '0;
        end else if (flush_i) begin
            hold_pc   <= '0;
            hold_inst <= '0;
        end else if (state == S_FETCH && imem.ack && stall_i) begin
            hold_pc   <= fetch_pc;
            hold_inst <= imem.rdata;
        end
    end

    // Decode-facing registers: deliver, bubble, or hold under stall.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RSTN_ENABLE) begin
            pc_o    <= '0;
            inst_o  <= '0;
            valid_o <= 1'b0;
        end else if (flush_i) begin
            pc_o    <= '0;
            inst_o  <= '0;
            valid_o <= 1'b0;
        end else if (!stall_i) begin
            pc_o    <= '0;
            inst_o  <= '0;
            valid_o <= 1'b0;
            unique case (state)
                S_FETCH: begin
                    if (imem.ack) begin
                        pc_o    <= fetch_pc;
                        inst_o  <= imem.rdata;
                        valid_o <= 1'b1;
                    end
                end
                S_HOLD: begin
                    pc_o    <= hold_pc;
                    inst_o  <= hold_inst;
                    valid_o <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for the if_fetch stage.
// Directed scenarios, then random traffic vs a transaction model.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [31:0] new_pc_i = '0;
    logic        branch_flag_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] pc_o;
    logic [31:0] inst_o;
    logic        valid_o;
    logic        stallreq_o;

    logic        ack_en = 1'b0;
    logic [31:0] ovr_addr = 32'hFFFF_FFFF;
    logic [31:0] ovr_data = '0;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } xfer_t;

    if_fetch_if imem ();

    assign imem.ack = ack_en & imem.req;
    assign imem.rdata = (imem.addr == ovr_addr) ? ovr_data
                                                : (imem.addr ^ 32'hA5A5_0000);

    if_fetch #(.RESET_PC(32'h0)) dut (
        .clk(clk),
        .rst(rst),
        .stall_i(stall_i),
        .flush_i(flush_i),
        .new_pc_i(new_pc_i),
        .branch_flag_i(branch_flag_i),
        .branch_target_i(branch_target_i),
        .imem(imem),
        .pc_o(pc_o),
        .inst_o(inst_o),
        .valid_o(valid_o),
        .stallreq_o(stallreq_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        ack_en = 1'b1;
        tick();
        tick();
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", imem.req); end
        total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", imem.addr); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rst_pc got=%h exp=0", pc_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rst_inst got=%h exp=0", inst_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", valid_o); end
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rst_stallreq got=%b exp=0", stallreq_o); end
    endtask

    task automatic test_stream();
        rst = 1'b1;
        #1;
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL idle_req got=%b exp=0", imem.req); end
        tick();
        total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL first_req got=%b exp=1", imem.req); end
        total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL first_addr got=%h exp=0", imem.addr); end
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL stream_stallreq got=%b exp=0", stallreq_o); end
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (pc_o !== 32'(k * 4)) begin bad++; $display("FAIL stream_pc%0d got=%h exp=%h", k, pc_o, 32'(k * 4)); end
            total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL stream_valid%0d got=%b exp=1", k, valid_o); end
            total++; if (inst_o !== (32'(k * 4) ^ 32'hA5A5_0000)) begin bad++; $display("FAIL stream_inst%0d got=%h", k, inst_o); end
        end
    endtask

    task automatic test_mem_wait();
        ack_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            total++; if (imem.addr !== 32'h8) begin bad++; $display("FAIL wait_addr%0d got=%h exp=8", k, imem.addr); end
            total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL wait_stallreq%0d got=%b exp=1", k, stallreq_o); end
            tick();
            total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL wait_bubble%0d got=%b exp=0", k, valid_o); end
        end
        total++; if (imem.addr !== 32'h8) begin bad++; $display("FAIL wait_addr2 got=%h exp=8", imem.addr); end
        ack_en = 1'b1;
        #1;
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL wait_ackcyc got=%b exp=0", stallreq_o); end
        tick();
        total++; if (pc_o !== 32'h8) begin bad++; $display("FAIL wait_pc got=%h exp=8", pc_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL wait_valid got=%b exp=1", valid_o); end
        total++; if (inst_o !== 32'hA5A5_0008) begin bad++; $display("FAIL wait_inst got=%h exp=a5a50008", inst_o); end
    endtask

    task automatic test_stall_hold();
        total++; if (imem.addr !== 32'hC) begin bad++; $display("FAIL hold_addr got=%h exp=c", imem.addr); end
        ovr_addr = 32'hC;
        ovr_data = 32'h3421_0010;
        stall_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            total++; if (pc_o !== 32'h8) begin bad++; $display("FAIL hold_pc%0d got=%h exp=8", k, pc_o); end
            total++; if (inst_o !== 32'hA5A5_0008) begin bad++; $display("FAIL hold_inst%0d got=%h", k, inst_o); end
            total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL hold_valid%0d got=%b exp=1", k, valid_o); end
            total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL hold_req%0d got=%b exp=0", k, imem.req); end
        end
        stall_i = 1'b0;
        tick();
        ovr_addr = 32'hFFFF_FFFF;
        total++; if (pc_o !== 32'hC) begin bad++; $display("FAIL unhold_pc got=%h exp=c", pc_o); end
        total++; if (inst_o !== 32'h3421_0010) begin bad++; $display("FAIL unhold_inst got=%h exp=34210010", inst_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL unhold_valid got=%b exp=1", valid_o); end
        total++; if (imem.addr !== 32'h10) begin bad++; $display("FAIL unhold_addr got=%h exp=10", imem.addr); end
    endtask

    task automatic test_branch();
        tick();
        total++; if (pc_o !== 32'h10) begin bad++; $display("FAIL br_pre_pc got=%h exp=10", pc_o); end
        total++; if (imem.addr !== 32'h14) begin bad++; $display("FAIL br_pre_addr got=%h exp=14", imem.addr); end
        ack_en = 1'b0;
        branch_flag_i = 1'b1;
        branch_target_i = 32'h103;
        tick();
        branch_flag_i = 1'b0;
        ack_en = 1'b1;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL br_bubble got=%b exp=0", valid_o); end
        total++; if (imem.addr !== 32'h14) begin bad++; $display("FAIL br_slot_addr got=%h exp=14", imem.addr); end
        tick();
        total++; if (pc_o !== 32'h14) begin bad++; $display("FAIL br_slot_pc got=%h exp=14", pc_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL br_slot_valid got=%b exp=1", valid_o); end
        total++; if (inst_o !== 32'hA5A5_0014) begin bad++; $display("FAIL br_slot_inst got=%h", inst_o); end
        total++; if (imem.addr !== 32'h100) begin bad++; $display("FAIL br_tgt_addr got=%h exp=100", imem.addr); end
        branch_flag_i = 1'b1;
        branch_target_i = 32'h20;
        tick();
        branch_flag_i = 1'b0;
        total++; if (pc_o !== 32'h100) begin bad++; $display("FAIL br2_pc got=%h exp=100", pc_o); end
        total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL br2_addr got=%h exp=20", imem.addr); end
    endtask

    task automatic test_flush();
        ack_en = 1'b0;
        flush_i = 1'b1;
        new_pc_i = 32'h80;
        ovr_addr = 32'h20;
        ovr_data = 32'hDEAD_BEEF;
        tick();
        flush_i = 1'b0;
        new_pc_i = 32'h0;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fl_bubble got=%b exp=0", valid_o); end
        total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL fl_req got=%b exp=1", imem.req); end
        total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL fl_addr0 got=%h exp=20", imem.addr); end
        #1;
        total++; if (stallreq_o !== 1'b1) begin bad++; $display("FAIL fl_stallreq got=%b exp=1", stallreq_o); end
        tick();
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fl_bubble1 got=%b exp=0", valid_o); end
        total++; if (imem.addr !== 32'h20) begin bad++; $display("FAIL fl_addr1 got=%h exp=20", imem.addr); end
        ack_en = 1'b1;
        tick();
        ovr_addr = 32'hFFFF_FFFF;
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL fl_drop_valid got=%b exp=0", valid_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL fl_drop_inst got=%h exp=0", inst_o); end
        total++; if (imem.addr !== 32'h80) begin bad++; $display("FAIL fl_new_addr got=%h exp=80", imem.addr); end
        tick();
        total++; if (pc_o !== 32'h80) begin bad++; $display("FAIL fl_new_pc got=%h exp=80", pc_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL fl_new_valid got=%b exp=1", valid_o); end
        total++; if (inst_o !== 32'hA5A5_0080) begin bad++; $display("FAIL fl_new_inst got=%h", inst_o); end
    endtask

    task automatic test_reset_in_hold();
        stall_i = 1'b1;
        tick();
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rh_req got=%b exp=0", imem.req); end
        #2;
        rst = 1'b0;
        #1;
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rh_rst_req got=%b exp=0", imem.req); end
        total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL rh_rst_addr got=%h exp=0", imem.addr); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL rh_rst_pc got=%h exp=0", pc_o); end
        total++; if (inst_o !== 32'h0) begin bad++; $display("FAIL rh_rst_inst got=%h exp=0", inst_o); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rh_rst_valid got=%b exp=0", valid_o); end
        total++; if (stallreq_o !== 1'b0) begin bad++; $display("FAIL rh_rst_stallreq got=%b exp=0", stallreq_o); end
        stall_i = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        total++; if (imem.req !== 1'b0) begin bad++; $display("FAIL rh_idle_req got=%b exp=0", imem.req); end
        tick();
        total++; if (imem.req !== 1'b1) begin bad++; $display("FAIL rh_first_req got=%b exp=1", imem.req); end
        total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL rh_first_addr got=%h exp=0", imem.addr); end
        total++; if (valid_o !== 1'b0) begin bad++; $display("FAIL rh_first_valid got=%b exp=0", valid_o); end
    endtask

    task automatic test_wrap();
        branch_flag_i = 1'b1;
        branch_target_i = 32'hFFFF_FFFC;
        tick();
        branch_flag_i = 1'b0;
        total++; if (imem.addr !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_top got=%h", imem.addr); end
        total++; if (pc_o !== 32'h0) begin bad++; $display("FAIL wrap_pc0 got=%h exp=0", pc_o); end
        tick();
        total++; if (pc_o !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc got=%h", pc_o); end
        total++; if (valid_o !== 1'b1) begin bad++; $display("FAIL wrap_valid got=%b exp=1", valid_o); end
        total++; if (imem.addr !== 32'h0) begin bad++; $display("FAIL wrap_addr got=%h exp=0", imem.addr); end
    endtask

    task automatic test_random();
        xfer_t       q[$];
        xfer_t       x;
        logic [31:0] exp_cur;
        logic [31:0] ovr;
        logic        has_ovr;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        logic        exp_valid;
        logic        exp_req;
        logic        br;
        logic [31:0] tgt;
        bit          quiet;
        int          n = 3000;

        rst = 1'b0;
        stall_i = 1'b0;
        branch_flag_i = 1'b0;
        ack_en = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        exp_cur = 32'h0;
        has_ovr = 1'b0;
        ovr = '0;
        exp_pc = '0;
        exp_inst = '0;
        exp_valid = 1'b0;
        for (int i = 0; i < n + 8; i++) begin
            quiet = (i >= n);
            exp_req = (i > 0) && (q.size() == 0);
            total++; if (pc_o !== exp_pc) begin bad++; $display("FAIL rnd_pc c%0d got=%h exp=%h", i, pc_o, exp_pc); end
            total++; if (inst_o !== exp_inst) begin bad++; $display("FAIL rnd_inst c%0d got=%h exp=%h", i, inst_o, exp_inst); end
            total++; if (valid_o !== exp_valid) begin bad++; $display("FAIL rnd_valid c%0d got=%b exp=%b", i, valid_o, exp_valid); end
            total++; if (imem.req !== exp_req) begin bad++; $display("FAIL rnd_req c%0d got=%b exp=%b", i, imem.req, exp_req); end
            if (exp_req) begin
                total++; if (imem.addr !== exp_cur) begin bad++; $display("FAIL rnd_addr c%0d got=%h exp=%h", i, imem.addr, exp_cur); end
            end
            stall_i = quiet ? 1'b0 : ($urandom_range(0, 9) < 3);
            ack_en = quiet ? 1'b1 : ($urandom_range(0, 9) < 6);
            br = !quiet && (i > 0) && ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            branch_flag_i = br;
            branch_target_i = tgt;
            #1;
            total++; if (stallreq_o !== (exp_req && !ack_en)) begin bad++; $display("FAIL rnd_stallreq c%0d got=%b", i, stallreq_o); end
            if (br) begin
                if (q.size() != 0) begin
                    exp_cur = tgt & 32'hFFFF_FFFC;
                end else begin
                    has_ovr = 1'b1;
                    ovr = tgt & 32'hFFFF_FFFC;
                end
            end
            if (exp_req && ack_en) begin
                x.pc = exp_cur;
                x.inst = exp_cur ^ 32'hA5A5_0000;
                q.push_back(x);
                exp_cur = has_ovr ? ovr : exp_cur + 32'd4;
                has_ovr = 1'b0;
            end
            if (!stall_i) begin
                if (q.size() != 0) begin
                    x = q.pop_front();
                    exp_pc = x.pc;
                    exp_inst = x.inst;
                    exp_valid = 1'b1;
                end else begin
                    exp_pc = '0;
                    exp_inst = '0;
                    exp_valid = 1'b0;
                end
            end
            tick();
        end
        branch_flag_i = 1'b0;
        total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_drain left=%0d exp=0", q.size()); end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_stream();
        test_mem_wait();
        test_stall_hold();
        test_branch();
        test_flush();
        test_reset_in_hold();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
